// File: rtl/moment_if.sv
// Cell-in / moments-out bundle for moment_calc.
// The fo_* forwarded-distribution signals exist only when MOMENT_FWD_EN is defined.
interface moment_if;
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // The producer holds data stable while valid is high; valid never waits on ready.
  logic [15:0] f_null, f_n, f_ne, f_e, f_se, f_s, f_sw, f_w, f_nw;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] rho, u_x, u_y;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;
  logic        div_err;
  logic        busy;
  logic [1:0]  state_dbg;
`ifdef MOMENT_FWD_EN
  logic [15:0] fo_null, fo_n, fo_ne, fo_e, fo_se, fo_s, fo_sw, fo_w, fo_nw;

  modport master (
    output f_null, f_n, f_ne, f_e, f_se, f_s, f_sw, f_w, f_nw, in_valid, out_ready,
    input  in_ready, rho, u_x, u_y, out_valid, ovf, div_err, busy, state_dbg,
    input  fo_null, fo_n, fo_ne, fo_e, fo_se, fo_s, fo_sw, fo_w, fo_nw
  );
  modport slave (
    input  f_null, f_n, f_ne, f_e, f_se, f_s, f_sw, f_w, f_nw, in_valid, out_ready,
    output in_ready, rho, u_x, u_y, out_valid, ovf, div_err, busy, state_dbg,
    output fo_null, fo_n, fo_ne, fo_e, fo_se, fo_s, fo_sw, fo_w, fo_nw
  );
`else
  modport master (
    output f_null, f_n, f_ne, f_e, f_se, f_s, f_sw, f_w, f_nw, in_valid, out_ready,
    input  in_ready, rho, u_x, u_y, out_valid, ovf, div_err, busy, state_dbg
  );
  modport slave (
    input  f_null, f_n, f_ne, f_e, f_se, f_s, f_sw, f_w, f_nw, in_valid, out_ready,
    output in_ready, rho, u_x, u_y, out_valid, ovf, div_err, busy, state_dbg
  );
`endif
endinterface

// File: rtl/moment_calc.sv
// Lattice-Boltzmann moment calculator: density and velocities of one D2Q9 cell via two serial dividers.
// Optional MOMENT_FWD_EN: latch the nine f inputs on accept and forward them as fo_* alongside the results.
module moment_calc #(
  parameter int FRAC_BITS = 13
) (
  input logic     clk,
  input logic     rst,
  moment_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  cnt;

  logic [15:0] sum_rho, sum_mx, sum_my;
  logic [15:0] rho_r, mx_r, my_r;
  logic        neg_x, neg_y, ovf_x, ovf_y, derr_r;
  logic [15:0] dvd_x, dvd_y;
  logic [15:0] rem_x, rem_y;
  logic [14:0] q_x, q_y;

  logic        in_ready_r, out_valid_r, busy_r, ovf_o, div_err_o;
  logic [15:0] rho_o, u_x_o, u_y_o;

  // Moment sums, all wrapping modulo 2^16.
  always_comb begin
    sum_rho = bus.f_null + bus.f_n + bus.f_ne + bus.f_e + bus.f_se
            + bus.f_s + bus.f_sw + bus.f_w + bus.f_nw;
    sum_mx  = bus.f_e - bus.f_w + bus.f_ne + bus.f_se - bus.f_sw - bus.f_nw;
    sum_my  = bus.f_n - bus.f_s + bus.f_ne + bus.f_nw - bus.f_sw - bus.f_se;
  end

  // PREP: magnitudes, scaled dividends and the saturation test |m|*2^F >= rho*2^15.
  logic [16:0] mag_x, mag_y;
  logic [31:0] pre_dvd_x, pre_dvd_y, rho_lim;
  logic        pre_derr;

  always_comb begin
    mag_x     = mx_r[15] ? (17'd0 - {1'b1, mx_r}) : {1'b0, mx_r};
    mag_y     = my_r[15] ? (17'd0 - {1'b1, my_r}) : {1'b0, my_r};
    pre_dvd_x = {15'd0, mag_x} << FRAC_BITS;
    pre_dvd_y = {15'd0, mag_y} << FRAC_BITS;
    rho_lim   = {17'd0, rho_r[14:0]} << 15;
    pre_derr  = rho_r[15] || (rho_r == 16'd0);
  end

  // DIV: one restoring step per axis. Without overflow the quotient fits in 15 bits,
  // so the partial remainder starts at dividend[31:16] and 16 steps consume bits 15..0.
  logic [16:0] sh_x, sh_y;
  logic [15:0] sub_x, sub_y, nrem_x, nrem_y, nq_x, nq_y;
  logic        ge_x, ge_y;
  logic [15:0] fin_x, fin_y;
  logic        fin_ovf;

  always_comb begin
    sh_x   = {rem_x, dvd_x[15]};
    sh_y   = {rem_y, dvd_y[15]};
    ge_x   = sh_x >= {1'b0, rho_r};
    ge_y   = sh_y >= {1'b0, rho_r};
    sub_x  = sh_x[15:0] - rho_r;
    sub_y  = sh_y[15:0] - rho_r;
    nrem_x = ge_x ? sub_x : sh_x[15:0];
    nrem_y = ge_y ? sub_y : sh_y[15:0];
    nq_x   = {q_x, ge_x};
    nq_y   = {q_y, ge_y};

    if (derr_r) begin
      fin_x = 16'h0000;
    end else if (ovf_x) begin
      fin_x = neg_x ? 16'h8001 : 16'h7FFF;
    end else begin
      fin_x = neg_x ? (16'd0 - nq_x) : nq_x;
    end

    if (derr_r) begin
      fin_y = 16'h0000;
    end else if (ovf_y) begin
      fin_y = neg_y ? 16'h8001 : 16'h7FFF;
    end else begin
      fin_y = neg_y ? (16'd0 - nq_y) : nq_y;
    end

    fin_ovf = !derr_r && (ovf_x || ovf_y);
  end

`ifdef MOMENT_FWD_EN
  logic [15:0] fo_null_r, fo_n_r, fo_ne_r, fo_e_r, fo_se_r, fo_s_r, fo_sw_r, fo_w_r, fo_nw_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      fo_null_r <= '0; fo_n_r  <= '0; fo_ne_r <= '0;
      fo_e_r    <= '0; fo_se_r <= '0; fo_s_r  <= '0;
      fo_sw_r   <= '0; fo_w_r  <= '0; fo_nw_r <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      fo_null_r <= bus.f_null; fo_n_r  <= bus.f_n;  fo_ne_r <= bus.f_ne;
      fo_e_r    <= bus.f_e;    fo_se_r <= bus.f_se; fo_s_r  <= bus.f_s;
      fo_sw_r   <= bus.f_sw;   fo_w_r  <= bus.f_w;  fo_nw_r <= bus.f_nw;
    end
  end

  assign bus.fo_null = fo_null_r;
  assign bus.fo_n    = fo_n_r;
  assign bus.fo_ne   = fo_ne_r;
  assign bus.fo_e    = fo_e_r;
  assign bus.fo_se   = fo_se_r;
  assign bus.fo_s    = fo_s_r;
  assign bus.fo_sw   = fo_sw_r;
  assign bus.fo_w    = fo_w_r;
  assign bus.fo_nw   = fo_nw_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      rho_r       <= '0;
      mx_r        <= '0;
      my_r        <= '0;
      neg_x       <= 1'b0;
      neg_y       <= 1'b0;
      ovf_x       <= 1'b0;
      ovf_y       <= 1'b0;
      derr_r      <= 1'b0;
      dvd_x       <= '0;
      dvd_y       <= '0;
      rem_x       <= '0;
      rem_y       <= '0;
      q_x         <= '0;
      q_y         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      ovf_o       <= 1'b0;
      div_err_o   <= 1'b0;
      rho_o       <= '0;
      u_x_o       <= '0;
      u_y_o       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rho_r      <= sum_rho;
            mx_r       <= sum_mx;
            my_r       <= sum_my;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= PREP;
          end
        end
        PREP: begin
          neg_x  <= mx_r[15];
          neg_y  <= my_r[15];
          ovf_x  <= pre_dvd_x >= rho_lim;
          ovf_y  <= pre_dvd_y >= rho_lim;
          derr_r <= pre_derr;
          dvd_x  <= pre_dvd_x[15:0];
          dvd_y  <= pre_dvd_y[15:0];
          rem_x  <= pre_dvd_x[31:16];
          rem_y  <= pre_dvd_y[31:16];
          q_x    <= '0;
          q_y    <= '0;
          cnt    <= 4'd0;
          state  <= DIV;
        end
        DIV: begin
          rem_x <= nrem_x;
          rem_y <= nrem_y;
          q_x   <= nq_x[14:0];
          q_y   <= nq_y[14:0];
          dvd_x <= {dvd_x[14:0], 1'b0};
          dvd_y <= {dvd_y[14:0], 1'b0};
          if (cnt == 4'd15) begin
            rho_o       <= rho_r;
            u_x_o       <= fin_x;
            u_y_o       <= fin_y;
            ovf_o       <= fin_ovf;
            div_err_o   <= derr_r;
            out_valid_r <= 1'b1;
            state       <= OUT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.rho       = rho_o;
  assign bus.u_x       = u_x_o;
  assign bus.u_y       = u_y_o;
  assign bus.ovf       = ovf_o;
  assign bus.div_err   = div_err_o;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_moment_calc.sv
// Directed bench for moment_calc: reset, vector table, backpressure, mid-flight reset, back-to-back rate.
module tb_moment_calc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  moment_if bus ();

  moment_calc #(.FRAC_BITS(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Cell index order: 0 null, 1 n, 2 ne, 3 e, 4 se, 5 s, 6 sw, 7 w, 8 nw.
  task automatic drive_cell(input logic [8:0][15:0] c);
    bus.f_null = c[0]; bus.f_n  = c[1]; bus.f_ne = c[2];
    bus.f_e    = c[3]; bus.f_se = c[4]; bus.f_s  = c[5];
    bus.f_sw   = c[6]; bus.f_w  = c[7]; bus.f_nw = c[8];
  endtask

  task automatic scramble_inputs();
    logic [8:0][15:0] r;
    for (int k = 0; k < 9; k++) r[k] = 16'($urandom);
    drive_cell(r);
    bus.in_valid  = 1'($urandom_range(0, 1));
    bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present a cell in IDLE and wait for out_valid; lat counts the accepting edge as 1.
  // Inputs are randomised while the cell is in flight.
  task automatic run_cell(input logic [8:0][15:0] c, output int lat);
    drive_cell(c);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      scramble_inputs();
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_cell('0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.out_valid, bus.busy, bus.in_ready, bus.ovf, bus.div_err} !== 5'b00100) begin
      bad++;
      $display("FAIL reset_flags: got ov/busy/ir/ovf/derr=%b want 00100",
               {bus.out_valid, bus.busy, bus.in_ready, bus.ovf, bus.div_err});
    end
    total++;
    if ({bus.rho, bus.u_x, bus.u_y} !== 48'd0 || bus.state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_data: got rho=%h ux=%h uy=%h st=%0d want 0 0 0 0",
               bus.rho, bus.u_x, bus.u_y, bus.state_dbg);
    end
`ifdef MOMENT_FWD_EN
    total++;
    if (bus.fo_null !== 16'h0 || bus.fo_e !== 16'h0 || bus.fo_nw !== 16'h0) begin
      bad++;
      $display("FAIL reset_fwd: got fo_null=%h fo_e=%h fo_nw=%h want 0", bus.fo_null, bus.fo_e, bus.fo_nw);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    localparam int NV = 13;
    logic [8:0][15:0] cells [NV];
    logic [15:0] e_rho [NV];
    logic [15:0] e_ux [NV];
    logic [15:0] e_uy [NV];
    logic        e_ovf [NV];
    logic        e_derr [NV];
    int lat;
    for (int i = 0; i < NV; i++) cells[i] = '0;
    // zero velocity
    cells[0][0] = 16'h2000;            e_rho[0] = 16'h2000; e_ux[0] = 16'h0000; e_uy[0] = 16'h0000; e_ovf[0] = 0; e_derr[0] = 0;
    // positive x
    cells[1][0] = 16'h1C00; cells[1][3] = 16'h0400;
    e_rho[1] = 16'h2000; e_ux[1] = 16'h0400; e_uy[1] = 16'h0000; e_ovf[1] = 0; e_derr[1] = 0;
    // negative x and y
    cells[2][0] = 16'h1C00; cells[2][6] = 16'h0400;
    e_rho[2] = 16'h2000; e_ux[2] = 16'hFC00; e_uy[2] = 16'hFC00; e_ovf[2] = 0; e_derr[2] = 0;
    // positive saturation
    cells[3][0] = 16'hE800; cells[3][3] = 16'h2000;
    e_rho[3] = 16'h0800; e_ux[3] = 16'h7FFF; e_uy[3] = 16'h0000; e_ovf[3] = 1; e_derr[3] = 0;
    // rho wraps to zero
    cells[4][3] = 16'h2000; cells[4][7] = 16'hE000;
    e_rho[4] = 16'h0000; e_ux[4] = 16'h0000; e_uy[4] = 16'h0000; e_ovf[4] = 0; e_derr[4] = 1;
    // negative saturation
    cells[5][0] = 16'hE800; cells[5][7] = 16'h2000;
    e_rho[5] = 16'h0800; e_ux[5] = 16'h8001; e_uy[5] = 16'h0000; e_ovf[5] = 1; e_derr[5] = 0;
    // truncation: 256*8192/12288 = 170.67
    cells[6][0] = 16'h2F00; cells[6][3] = 16'h0100;
    e_rho[6] = 16'h3000; e_ux[6] = 16'h00AA; e_uy[6] = 16'h0000; e_ovf[6] = 0; e_derr[6] = 0;
    // truncation toward zero on the negative side
    cells[7][0] = 16'h2F00; cells[7][7] = 16'h0100;
    e_rho[7] = 16'h3000; e_ux[7] = 16'hFF56; e_uy[7] = 16'h0000; e_ovf[7] = 0; e_derr[7] = 0;
    // negative rho
    cells[8][0] = 16'hF000;
    e_rho[8] = 16'hF000; e_ux[8] = 16'h0000; e_uy[8] = 16'h0000; e_ovf[8] = 0; e_derr[8] = 1;
    // positive y
    cells[9][0] = 16'h1C00; cells[9][1] = 16'h0400;
    e_rho[9] = 16'h2000; e_ux[9] = 16'h0000; e_uy[9] = 16'h0400; e_ovf[9] = 0; e_derr[9] = 0;
    // diagonal: u = 1.0 on both axes
    cells[10][2] = 16'h1000;
    e_rho[10] = 16'h1000; e_ux[10] = 16'h2000; e_uy[10] = 16'h2000; e_ovf[10] = 0; e_derr[10] = 0;
    // one below the saturation edge: 4095*8 = 32760
    cells[11][0] = 16'hF401; cells[11][3] = 16'h0FFF;
    e_rho[11] = 16'h0400; e_ux[11] = 16'h7FF8; e_uy[11] = 16'h0000; e_ovf[11] = 0; e_derr[11] = 0;
    // exactly on the saturation edge
    cells[12][0] = 16'hF400; cells[12][3] = 16'h1000;
    e_rho[12] = 16'h0400; e_ux[12] = 16'h7FFF; e_uy[12] = 16'h0000; e_ovf[12] = 1; e_derr[12] = 0;

    for (int i = 0; i < NV; i++) begin
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL vec%0d_in_ready: got %b want 1", i, bus.in_ready);
      end
      run_cell(cells[i], lat);
      total++;
      if (lat !== 18) begin
        bad++;
        $display("FAIL vec%0d_latency: got %0d want 18", i, lat);
      end
      total++;
      if (bus.rho !== e_rho[i] || bus.u_x !== e_ux[i] || bus.u_y !== e_uy[i]) begin
        bad++;
        $display("FAIL vec%0d_data: got rho=%h ux=%h uy=%h want rho=%h ux=%h uy=%h",
                 i, bus.rho, bus.u_x, bus.u_y, e_rho[i], e_ux[i], e_uy[i]);
      end
      total++;
      if (bus.ovf !== e_ovf[i] || bus.div_err !== e_derr[i]) begin
        bad++;
        $display("FAIL vec%0d_flags: got ovf=%b derr=%b want ovf=%b derr=%b",
                 i, bus.ovf, bus.div_err, e_ovf[i], e_derr[i]);
      end
`ifdef MOMENT_FWD_EN
      total++;
      if (bus.fo_null !== cells[i][0] || bus.fo_e !== cells[i][3] || bus.fo_w !== cells[i][7]
          || bus.fo_sw !== cells[i][6]) begin
        bad++;
        $display("FAIL vec%0d_fwd: got null=%h e=%h w=%h sw=%h want %h %h %h %h", i,
                 bus.fo_null, bus.fo_e, bus.fo_w, bus.fo_sw, cells[i][0], cells[i][3], cells[i][7], cells[i][6]);
      end
`endif
      release_out();
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL vec%0d_release: got ov=%b ir=%b busy=%b want 0 1 0",
                 i, bus.out_valid, bus.in_ready, bus.busy);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0][15:0] c;
    int lat;
    c = '0;
    c[0] = 16'h1C00;
    c[3] = 16'h0400;
    run_cell(c, lat);
    for (int k = 0; k < 5; k++) begin
      // offer a different cell while blocked; it must be ignored
      c[3] = 16'($urandom);
      drive_cell(c);
      bus.in_valid = 1'b1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.rho !== 16'h2000
          || bus.u_x !== 16'h0400 || bus.u_y !== 16'h0000 || bus.ovf !== 1'b0) begin
        bad++;
        $display("FAIL hold%0d: got ov=%b ir=%b rho=%h ux=%h uy=%h ovf=%b want 1 0 2000 0400 0000 0",
                 k, bus.out_valid, bus.in_ready, bus.rho, bus.u_x, bus.u_y, bus.ovf);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    release_out();
    total++;
    if (bus.out_valid !== 1'b0 || bus.state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL hold_release: got ov=%b st=%0d want 0 0", bus.out_valid, bus.state_dbg);
    end
  endtask

  task automatic test_reset_mid_div();
    logic [8:0][15:0] c;
    int seen;
    c = '0;
    c[0] = 16'h1C00;
    c[3] = 16'h0400;
    drive_cell(c);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    total++;
    if (bus.state_dbg !== 2'd2 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_div_state: got st=%0d busy=%b ir=%b want 2 1 0", bus.state_dbg, bus.busy, bus.in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (bus.state_dbg !== 2'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL div_reset: got st=%0d ir=%b ov=%b busy=%b want 0 1 0 0",
               bus.state_dbg, bus.in_ready, bus.out_valid, bus.busy);
    end
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL div_reset_no_pulse: got %0d out_valid cycles want 0", seen);
    end
  endtask

  task automatic test_reset_mid_out();
    logic [8:0][15:0] c;
    int lat;
    c = '0;
    c[0] = 16'h1C00;
    c[6] = 16'h0400;
    run_cell(c, lat);
    total++;
    if (bus.out_valid !== 1'b1 || bus.u_x !== 16'hFC00) begin
      bad++;
      $display("FAIL out_before_reset: got ov=%b ux=%h want 1 fc00", bus.out_valid, bus.u_x);
    end
    // reset and a handshake on the same edge: reset wins
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.rho !== 16'h0 || bus.u_x !== 16'h0 || bus.u_y !== 16'h0
        || bus.state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL out_reset: got ov=%b rho=%h ux=%h uy=%h st=%0d want 0 0 0 0 0",
               bus.out_valid, bus.rho, bus.u_x, bus.u_y, bus.state_dbg);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0][15:0] c;
    int acc [3];
    int n_acc;
    int n_out;
    int cyc;
    c = '0;
    c[0] = 16'h1C00;
    c[1] = 16'h0400;
    drive_cell(c);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    n_acc = 0;
    n_out = 0;
    cyc = 0;
    while (n_acc < 3 && cyc < 80) begin
      if (bus.in_valid && bus.in_ready) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      if (bus.out_valid) begin
        n_out++;
        total++;
        if (bus.u_y !== 16'h0400 || bus.u_x !== 16'h0000 || bus.rho !== 16'h2000) begin
          bad++;
          $display("FAIL b2b_data: got rho=%h ux=%h uy=%h want 2000 0000 0400", bus.rho, bus.u_x, bus.u_y);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    total++;
    if (n_acc !== 3 || n_out !== 2) begin
      bad++;
      $display("FAIL b2b_count: got accepts=%0d outs=%0d want 3 2", n_acc, n_out);
    end else begin
      total++;
      if (acc[1] - acc[0] !== 19 || acc[2] - acc[1] !== 19) begin
        bad++;
        $display("FAIL b2b_interval: got %0d %0d want 19 19", acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    repeat (25) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: got ir=%b ov=%b want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_div();
    test_reset_mid_out();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
